ifid_imm_reg: RTL and testbench

Parametrised IF/ID pipeline register with integrated immediate generation for the RISC-V core. It accepts fetched instructions through a valid/ready handshake and decodes the instruction format and the sign-extended immediate to XLEN bits. It holds results in a two-entry skid buffer so the fetch side sees full throughput under decode backpressure. It sits between the fetch unit and the ID/register-file stage and supports pipeline flush.

---
 rtl/ifid_imm_reg.sv | 236 +++++++++++++++++++++++
 tb/tb_ifid_imm_reg.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_imm_reg.sv
// IF/ID pipeline register with RISC-V format/immediate decode feeding a two-entry skid buffer.
// Optional feature: define IFID_ILLEGAL_EN to add the out_illegal flag for unrecognised opcodes.
`timescale 1ns/1ps
module ifid_imm_reg #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
`ifdef IFID_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] FMT_NONE = 3'b000;
  localparam logic [2:0] FMT_R    = 3'b001;
  localparam logic [2:0] FMT_U    = 3'b010;
  localparam logic [2:0] FMT_B    = 3'b011;
  localparam logic [2:0] FMT_I    = 3'b100;
  localparam logic [2:0] FMT_J    = 3'b101;
  localparam logic [2:0] FMT_JALR = 3'b110;
  localparam logic [2:0] FMT_LS   = 3'b111;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_in_ready;
  logic              w_in_fire;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  logic [6:0]        w_opcode;
  logic [2:0]        w_fmt;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm;

  logic [31:0]       r_main_inst;
  logic [PC_W-1:0]   r_main_pc;
  logic [XLEN-1:0]   r_main_imm;
  logic [2:0]        r_main_fmt;
  logic [31:0]       r_skid_inst;
  logic [PC_W-1:0]   r_skid_pc;
  logic [XLEN-1:0]   r_skid_imm;
  logic [2:0]        r_skid_fmt;

  assign w_opcode = in_inst[6:0];

  always_comb begin
    w_fmt   = FMT_NONE;
    w_imm32 = '0;
    case (w_opcode)
      OP_R: w_fmt = FMT_R;
      OP_LUI, OP_AUIPC: begin
        w_fmt   = FMT_U;
        w_imm32 = {in_inst[31:12], 12'b0};
      end
      OP_BR: begin
        w_fmt   = FMT_B;
        w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      OP_IALU: begin
        w_fmt   = FMT_I;
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_JAL: begin
        w_fmt   = FMT_J;
        w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        w_fmt   = FMT_JALR;
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_LOAD: begin
        w_fmt   = FMT_LS;
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        w_fmt   = FMT_LS;
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      default: ;
    endcase
  end

  // Signed cast sign-extends the 32-bit immediate to XLEN.
  assign w_imm = XLEN'(w_imm32);

  assign in_ready  = ~rst & r_in_ready;
  assign w_in_fire = in_valid & in_ready;
  assign out_valid = (r_state != S_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
    end
  end

  always_comb begin
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_next         = S_ONE;
            w_load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire) begin
            if (out_ready) begin
              w_load_main_in = 1'b1;
            end else begin
              w_load_skid = 1'b1;
              w_next      = S_TWO;
            end
          end else if (out_ready) begin
            w_next = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            w_load_main_skid = 1'b1;
            w_next           = S_ONE;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Data registers move only on a load; flush clears validity, not contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_inst <= '0;
      r_main_pc   <= '0;
      r_main_imm  <= '0;
      r_main_fmt  <= '0;
      r_skid_inst <= '0;
      r_skid_pc   <= '0;
      r_skid_imm  <= '0;
      r_skid_fmt  <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_inst <= in_inst;
        r_main_pc   <= in_pc;
        r_main_imm  <= w_imm;
        r_main_fmt  <= w_fmt;
      end else if (w_load_main_skid) begin
        r_main_inst <= r_skid_inst;
        r_main_pc   <= r_skid_pc;
        r_main_imm  <= r_skid_imm;
        r_main_fmt  <= r_skid_fmt;
      end
      if (w_load_skid) begin
        r_skid_inst <= in_inst;
        r_skid_pc   <= in_pc;
        r_skid_imm  <= w_imm;
        r_skid_fmt  <= w_fmt;
      end
    end
  end

  assign out_inst = r_main_inst;
  assign out_pc   = r_main_pc;
  assign out_imm  = r_main_imm;
  assign out_fmt  = r_main_fmt;

`ifdef IFID_ILLEGAL_EN
  logic w_illegal;
  logic r_main_ill;
  logic r_skid_ill;

  // An all-zero word has no valid opcode either, so every format-000 word is illegal.
  assign w_illegal = (w_fmt == FMT_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_ill <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_main_in) begin
        r_main_ill <= w_illegal;
      end else if (w_load_main_skid) begin
        r_main_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_ill <= w_illegal;
      end
    end
  end

  assign out_illegal = r_main_ill;
`else
  // Unknown opcodes flow through as format 000 with a zero immediate.
`endif

endmodule

// File: tb/tb_ifid_imm_reg.sv
// Directed bench for ifid_imm_reg: one XLEN=32 and one XLEN=64 instance share the same stimulus.
`timescale 1ns/1ps
module tb_ifid_imm_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [31:0] inInst;
  logic [31:0] inPc;
  logic        flush;
  logic        outReady;

  logic        inReady32, outValid32;
  logic [31:0] outInst32, outPc32, outImm32;
  logic [2:0]  outFmt32;
  logic        inReady64, outValid64;
  logic [31:0] outInst64, outPc64;
  logic [63:0] outImm64;
  logic [2:0]  outFmt64;
`ifdef IFID_ILLEGAL_EN
  logic        outIllegal32, outIllegal64;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  ifid_imm_reg #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady32),
    .in_inst(inInst), .in_pc(inPc), .flush(flush), .out_valid(outValid32),
    .out_ready(outReady), .out_inst(outInst32), .out_pc(outPc32),
    .out_imm(outImm32), .out_fmt(outFmt32)
`ifdef IFID_ILLEGAL_EN
    , .out_illegal(outIllegal32)
`endif
  );

  ifid_imm_reg #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady64),
    .in_inst(inInst), .in_pc(inPc), .flush(flush), .out_valid(outValid64),
    .out_ready(outReady), .out_inst(outInst64), .out_pc(outPc64),
    .out_imm(outImm64), .out_fmt(outFmt64)
`ifdef IFID_ILLEGAL_EN
    , .out_illegal(outIllegal64)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    inValid  = 1'b0;
    flush    = 1'b0;
    outReady = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1; inValid = 1'b0; inInst = '0; inPc = '0; flush = 1'b0; outReady = 1'b0;
    step();
    nCompared++;
    if (outValid32 !== 1'b0 || outValid64 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_valid: got %b/%b expected 0", outValid32, outValid64);
    end
    nCompared++;
    if (inReady32 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_in_ready_high: got %b expected 0", inReady32);
    end
    nCompared++;
    if (outInst32 !== 32'h0 || outPc32 !== 32'h0 || outImm32 !== 32'h0 || outFmt32 !== 3'b000 || outImm64 !== 64'h0) begin
      nMismatched++; $display("[TB] FAIL reset_data: inst %h pc %h imm %h fmt %b imm64 %h expected all 0", outInst32, outPc32, outImm32, outFmt32, outImm64);
    end
    rst = 1'b0;
    #1;
    nCompared++;
    if (inReady32 !== 1'b1 || inReady64 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL reset_release_in_ready: got %b/%b expected 1", inReady32, inReady64);
    end
  endtask

  task automatic test_addi;
    outReady = 1'b1; inValid = 1'b1; inInst = 32'hFFF00093; inPc = 32'h100;
    step();
    inValid = 1'b0;
    nCompared++;
    if (outValid32 !== 1'b1 || outImm32 !== 32'hFFFFFFFF || outFmt32 !== 3'b100 || outPc32 !== 32'h100 || outInst32 !== 32'hFFF00093) begin
      nMismatched++; $display("[TB] FAIL addi: valid %b imm %h fmt %b pc %h expected 1 ffffffff 100 00000100", outValid32, outImm32, outFmt32, outPc32);
    end
    step();
    nCompared++;
    if (outValid32 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL addi_consumed: valid %b expected 0", outValid32);
    end
  endtask

  task automatic test_back_to_back;
    outReady = 1'b1; inValid = 1'b1; inInst = 32'hFE000EE3; inPc = 32'h200;
    step();
    nCompared++;
    if (outValid32 !== 1'b1 || outImm32 !== 32'hFFFFFFFC || outFmt32 !== 3'b011 || outPc32 !== 32'h200) begin
      nMismatched++; $display("[TB] FAIL b2b_beq: valid %b imm %h fmt %b pc %h expected 1 fffffffc 011 00000200", outValid32, outImm32, outFmt32, outPc32);
    end
    inInst = 32'h123452B7; inPc = 32'h204;
    step();
    inValid = 1'b0;
    nCompared++;
    if (outValid32 !== 1'b1 || outImm32 !== 32'h12345000 || outFmt32 !== 3'b010 || outPc32 !== 32'h204) begin
      nMismatched++; $display("[TB] FAIL b2b_lui: valid %b imm %h fmt %b pc %h expected 1 12345000 010 00000204", outValid32, outImm32, outFmt32, outPc32);
    end
    step();
  endtask

  task automatic test_jal64;
    outReady = 1'b1; inValid = 1'b1; inInst = 32'hFF9FF06F; inPc = 32'h300;
    step();
    inValid = 1'b0;
    nCompared++;
    if (outValid64 !== 1'b1 || outImm64 !== 64'hFFFFFFFFFFFFFFF8 || outFmt64 !== 3'b101) begin
      nMismatched++; $display("[TB] FAIL jal64: valid %b imm %h fmt %b expected 1 fffffffffffffff8 101", outValid64, outImm64, outFmt64);
    end
    nCompared++;
    if (outImm32 !== 32'hFFFFFFF8 || outFmt32 !== 3'b101) begin
      nMismatched++; $display("[TB] FAIL jal32: imm %h fmt %b expected fffffff8 101", outImm32, outFmt32);
    end
    step();
  endtask

  task automatic test_formats;
    logic [31:0] fInst [8];
    logic [31:0] fImm [8];
    logic [2:0]  fFmt [8];
    logic        fIll [8];
    logic [63:0] exp64;
    fInst[0] = 32'h003100B3; fImm[0] = 32'h00000000; fFmt[0] = 3'b001; fIll[0] = 1'b0;
    fInst[1] = 32'h00001097; fImm[1] = 32'h00001000; fFmt[1] = 3'b010; fIll[1] = 1'b0;
    fInst[2] = 32'h00008067; fImm[2] = 32'h00000000; fFmt[2] = 3'b110; fIll[2] = 1'b0;
    fInst[3] = 32'h00812083; fImm[3] = 32'h00000008; fFmt[3] = 3'b111; fIll[3] = 1'b0;
    fInst[4] = 32'hFE512A23; fImm[4] = 32'hFFFFFFF4; fFmt[4] = 3'b111; fIll[4] = 1'b0;
    fInst[5] = 32'h0000007F; fImm[5] = 32'h00000000; fFmt[5] = 3'b000; fIll[5] = 1'b1;
    fInst[6] = 32'h00000000; fImm[6] = 32'h00000000; fFmt[6] = 3'b000; fIll[6] = 1'b1;
    fInst[7] = 32'h00100093; fImm[7] = 32'h00000001; fFmt[7] = 3'b100; fIll[7] = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1; inInst = fInst[i]; inPc = 32'h400 + 32'(i * 4);
      step();
      exp64 = {{32{fImm[i][31]}}, fImm[i]};
      nCompared++;
      if (outValid32 !== 1'b1 || outInst32 !== fInst[i] || outImm32 !== fImm[i] || outFmt32 !== fFmt[i] || outPc32 !== 32'h400 + 32'(i * 4)) begin
        nMismatched++; $display("[TB] FAIL fmt_%0d: valid %b inst %h imm %h fmt %b pc %h expected inst %h imm %h fmt %b", i, outValid32, outInst32, outImm32, outFmt32, outPc32, fInst[i], fImm[i], fFmt[i]);
      end
      nCompared++;
      if (outImm64 !== exp64 || outFmt64 !== fFmt[i]) begin
        nMismatched++; $display("[TB] FAIL fmt64_%0d: imm %h fmt %b expected %h %b", i, outImm64, outFmt64, exp64, fFmt[i]);
      end
`ifdef IFID_ILLEGAL_EN
      nCompared++;
      if (outIllegal32 !== fIll[i] || outIllegal64 !== fIll[i]) begin
        nMismatched++; $display("[TB] FAIL illegal_%0d: got %b/%b expected %b", i, outIllegal32, outIllegal64, fIll[i]);
      end
`endif
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_backpressure;
    outReady = 1'b0; inValid = 1'b1; inInst = 32'h00100093; inPc = 32'h0;
    step();
    nCompared++;
    if (outPc32 !== 32'h0 || inReady32 !== 1'b1 || outValid32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bp_first: pc %h in_ready %b valid %b expected 0 1 1", outPc32, inReady32, outValid32);
    end
    inInst = 32'h00200093; inPc = 32'h4;
    step();
    nCompared++;
    if (inReady32 !== 1'b0 || outPc32 !== 32'h0) begin
      nMismatched++; $display("[TB] FAIL bp_full: in_ready %b pc %h expected 0 0", inReady32, outPc32);
    end
    inInst = 32'h00300093; inPc = 32'h8;
    step();
    nCompared++;
    if (inReady32 !== 1'b0 || outPc32 !== 32'h0 || outImm32 !== 32'h1 || outValid32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bp_hold: in_ready %b pc %h imm %h valid %b expected 0 0 1 1", inReady32, outPc32, outImm32, outValid32);
    end
    outReady = 1'b1;
    #1;
    nCompared++;
    if (inReady32 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL bp_no_comb_ready: in_ready %b expected 0", inReady32);
    end
    step();
    nCompared++;
    if (outPc32 !== 32'h4 || outImm32 !== 32'h2 || inReady32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bp_second: pc %h imm %h in_ready %b expected 4 2 1", outPc32, outImm32, inReady32);
    end
    step();
    inValid = 1'b0;
    nCompared++;
    if (outPc32 !== 32'h8 || outImm32 !== 32'h3 || outValid32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bp_third: pc %h imm %h valid %b expected 8 3 1", outPc32, outImm32, outValid32);
    end
    step();
    nCompared++;
    if (outValid32 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL bp_empty: valid %b expected 0", outValid32);
    end
  endtask

  task automatic test_flush;
    outReady = 1'b0; inValid = 1'b1; inInst = 32'h00100093; inPc = 32'h500;
    step();
    inPc = 32'h504;
    step();
    inPc = 32'h508; flush = 1'b1;
    step();
    flush = 1'b0; inValid = 1'b0;
    nCompared++;
    if (outValid32 !== 1'b0 || inReady32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL flush_two: valid %b in_ready %b expected 0 1", outValid32, inReady32);
    end
    inValid = 1'b1; inPc = 32'h600;
    step();
    inPc = 32'h604; flush = 1'b1;
    step();
    flush = 1'b0; inValid = 1'b0;
    nCompared++;
    if (outValid32 !== 1'b0 || inReady32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL flush_one_drop: valid %b in_ready %b expected 0 1", outValid32, inReady32);
    end
    step();
    nCompared++;
    if (outValid32 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL flush_ghost: valid %b pc %h expected 0", outValid32, outPc32);
    end
    inValid = 1'b1; inPc = 32'h700; outReady = 1'b1;
    step();
    inValid = 1'b0;
    nCompared++;
    if (outValid32 !== 1'b1 || outPc32 !== 32'h700) begin
      nMismatched++; $display("[TB] FAIL flush_resume: valid %b pc %h expected 1 700", outValid32, outPc32);
    end
    step();
  endtask

  task automatic test_reset_mid;
    outReady = 1'b0; inValid = 1'b1; inInst = 32'hFFF00093; inPc = 32'h800;
    step();
    inPc = 32'h804;
    step();
    rst = 1'b1; inValid = 1'b0;
    step();
    nCompared++;
    if (outValid32 !== 1'b0 || inReady32 !== 1'b0 || outInst32 !== 32'h0 || outPc32 !== 32'h0 || outImm32 !== 32'h0 || outFmt32 !== 3'b000 || outImm64 !== 64'h0) begin
      nMismatched++; $display("[TB] FAIL reset_mid: valid %b in_ready %b inst %h pc %h imm %h fmt %b expected all 0", outValid32, inReady32, outInst32, outPc32, outImm32, outFmt32);
    end
`ifdef IFID_ILLEGAL_EN
    nCompared++;
    if (outIllegal32 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_mid_illegal: got %b expected 0", outIllegal32);
    end
`endif
    rst = 1'b0;
    outReady = 1'b1;
    step();
    nCompared++;
    if (outValid32 !== 1'b0 || inReady32 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL reset_mid_after: valid %b in_ready %b expected 0 1", outValid32, inReady32);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal64();
    test_formats();
    drain();
    test_backpressure();
    drain();
    test_flush();
    drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
